// File: rtl/collatz_host_if.sv
// rtl/collatz_host_if.sv - host request/response handshake bundle for collatz_host
interface collatz_host_if #(
    parameter int BITS = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [BITS-1:0] req_num;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_orbit;
    logic [BITS-1:0] rsp_record;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_num, rsp_ready,
        output req_ready, rsp_valid, rsp_orbit, rsp_record, rsp_err
    );

    modport master (
        output req_valid, req_num, rsp_ready,
        input  req_ready, rsp_valid, rsp_orbit, rsp_record, rsp_err
    );
endinterface

// File: rtl/collatz_host.sv
// rtl/collatz_host.sv - sequences one accelerator run per host request
// (byte-wise operand write, start, busy poll with timeout, pipelined result read).
module collatz_host #(
    parameter int          BITS           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    collatz_host_if.slave        host,
    output logic [7:0]           o_dev_wdata,
    output logic [7:0]           o_dev_ctrl,
    input  logic [7:0]           i_dev_rdata,
    input  logic                 i_dev_busy
);
    localparam int          NBYTES  = BITS / 8;
    localparam logic [31:0] NB      = 32'(NBYTES);
    localparam logic [3:0]  NB4     = 4'(NBYTES);
    localparam logic [31:0] RD_LAST = 32'(2 * NBYTES);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WRITE, S_START, S_ENTER, S_POLL,
        S_SETTLE, S_READ, S_RESP, S_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_cnt;
    logic [BITS-1:0]     r_wshift;
    logic [2*BITS-1:0]   r_rshift;
    logic [2*BITS-1:0]   w_rshift_next;
    logic [BITS-1:0]     r_prev_raw;
    logic [BITS-1:0]     r_orbit;
    logic [BITS-1:0]     r_record;
    logic                r_err;
    logic [3:0]          w_rd_off;

    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_accept;
    logic                w_timeout;
    logic                w_read_done;
    logic                w_req_ready;
    logic                w_rsp_valid;
    logic [7:0]          w_ctrl;
    logic [7:0]          w_wdata;

    // Record bytes follow orbit bytes, so one wrap-around offset suffices.
    assign w_rd_off      = r_cnt[3:0] - NB4;
    assign w_rshift_next = {i_dev_rdata, r_rshift[2*BITS-1:8]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_read_done = 1'b0;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_ctrl      = 8'h80;
        w_wdata     = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (host.req_valid) begin
                    w_accept  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = S_WRITE;
                end
            end
            S_WRITE: begin
                w_ctrl  = {4'b0000, r_cnt[3:0]};
                w_wdata = r_wshift[7:0];
                if (r_cnt == NB - 32'd1) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_START;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_START: begin
                w_ctrl    = 8'hC0;
                w_cnt_clr = 1'b1;
                w_next    = S_ENTER;
            end
            S_ENTER: begin
                // Busy may lag the start strobe, so it is not trusted yet.
                if (r_cnt == 32'd1) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_POLL;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_POLL: begin
                if (!i_dev_busy) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_SETTLE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_SETTLE: begin
                w_cnt_clr = 1'b1;
                w_next    = S_READ;
            end
            S_READ: begin
                if (r_cnt < NB) begin
                    w_ctrl = {4'b1000, r_cnt[3:0]};
                end else if (r_cnt < RD_LAST) begin
                    w_ctrl = {4'b1001, w_rd_off};
                end
                if (r_cnt == RD_LAST) begin
                    w_read_done = 1'b1;
                    w_next      = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    w_next = r_err ? S_LOCKED : S_IDLE;
                end
            end
            S_LOCKED: begin
                w_next = S_LOCKED;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_wshift   <= '0;
            r_rshift   <= '0;
            r_prev_raw <= '0;
            r_orbit    <= '0;
            r_record   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_accept) begin
                r_wshift <= host.req_num;
            end else if (r_state == S_WRITE) begin
                r_wshift <= r_wshift >> 8;
            end

            // Read data lags the address by one cycle; nothing is valid in cycle 0.
            if (r_state == S_READ && r_cnt != 32'd0) begin
                r_rshift <= w_rshift_next;
            end

            if (w_read_done) begin
                r_orbit    <= w_rshift_next[BITS-1:0] - r_prev_raw;
                r_record   <= w_rshift_next[2*BITS-1:BITS];
                r_prev_raw <= w_rshift_next[BITS-1:0];
                r_err      <= 1'b0;
            end else if (w_timeout) begin
                r_orbit  <= '0;
                r_record <= '0;
                r_err    <= 1'b1;
            end
        end
    end

    assign host.req_ready  = w_req_ready & i_rst_n;
    assign host.rsp_valid  = w_rsp_valid;
    assign host.rsp_orbit  = r_orbit;
    assign host.rsp_record = r_record;
    assign host.rsp_err    = r_err;
    assign o_dev_ctrl      = w_ctrl;
    assign o_dev_wdata     = w_wdata;
endmodule

// File: tb/tb_collatz_host.sv
// tb/tb_collatz_host.sv - directed and randomized runs against an accelerator model
module tb_collatz_host;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dev_wdata, dev_ctrl, dev_rdata;
    logic       dev_busy;
    logic [7:0] to_wdata, to_ctrl;
    logic [7:0] to_rdata = 8'h00;
    logic       to_busy = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_prev = '0;
    logic [31:0] set_orbit = '0, set_record = '0;
    int          set_busy = 0;

    logic [7:0] m_wmem [16];
    logic [7:0] m_orb [4];
    logic [7:0] m_rec [4];
    int         m_busy_cnt;

    collatz_host_if #(.BITS(32)) hif ();
    collatz_host_if #(.BITS(32)) hif_to ();

    collatz_host #(.BITS(32), .TIMEOUT_CYCLES(24'hFFFFFF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .host(hif),
        .o_dev_wdata(dev_wdata), .o_dev_ctrl(dev_ctrl),
        .i_dev_rdata(dev_rdata), .i_dev_busy(dev_busy)
    );

    collatz_host #(.BITS(32), .TIMEOUT_CYCLES(16)) dut_to (
        .i_clk(clk), .i_rst_n(rst_n), .host(hif_to),
        .o_dev_wdata(to_wdata), .o_dev_ctrl(to_ctrl),
        .i_dev_rdata(to_rdata), .i_dev_busy(to_busy)
    );

    always #5 clk = ~clk;

    // Accelerator: write mode captures bytes, start loads results and raises busy,
    // read mode returns the selected byte one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_cnt <= 0;
            dev_rdata  <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                m_orb[i] <= 8'h00;
                m_rec[i] <= 8'h00;
            end
        end else begin
            if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
            if (dev_ctrl == 8'hC0) begin
                m_busy_cnt <= set_busy;
                for (int i = 0; i < 4; i++) begin
                    m_orb[i] <= set_orbit[8*i +: 8];
                    m_rec[i] <= set_record[8*i +: 8];
                end
            end else if (!dev_ctrl[7]) begin
                m_wmem[dev_ctrl[3:0]] <= dev_wdata;
            end
            if (dev_ctrl[7]) begin
                if (dev_ctrl[3:2] != 2'b00) dev_rdata <= 8'hEE;
                else dev_rdata <= dev_ctrl[4] ? m_rec[dev_ctrl[1:0]] : m_orb[dev_ctrl[1:0]];
            end
        end
    end
    assign dev_busy = (m_busy_cnt != 0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] num, input int busy, input logic [31:0] raw_o,
                       input logic [31:0] raw_r, input int hold);
        logic [15:0] log_q [$];
        logic [7:0]  rd_exp [9];
        logic [31:0] exp_o, so, sr;
        int n, l;
        rd_exp = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'h91, 8'h92, 8'h93, 8'h80};
        set_orbit = raw_o; set_record = raw_r; set_busy = busy;
        exp_o = raw_o - ref_prev;
        @(negedge clk);
        chk("idle_ready", hif.req_ready, 1);
        chk("idle_ctrl", {dev_ctrl, dev_wdata}, 16'h8000);
        hif.req_valid = 1'b1; hif.req_num = num;
        @(negedge clk);
        hif.req_valid = 1'b0; hif.req_num = $urandom;
        n = 0;
        while (!hif.rsp_valid && n < 400) begin
            log_q.push_back({dev_ctrl, dev_wdata});
            chk("busy_ready", hif.req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", hif.rsp_valid, 1);
        l = log_q.size();
        if (hif.rsp_valid && l >= 16) begin
            for (int k = 0; k < 4; k++) chk("wr_seq", log_q[k], {8'(k), num[8*k +: 8]});
            chk("start", log_q[4], 16'hC000);
            chk("enter0", log_q[5][15:8], 8'h80);
            chk("enter1", log_q[6][15:8], 8'h80);
            for (int j = 0; j < 9; j++) chk("rd_addr", log_q[l-9+j][15:8], rd_exp[j]);
            chk("dev_num", {m_wmem[3], m_wmem[2], m_wmem[1], m_wmem[0]}, num);
            chk("orbit", hif.rsp_orbit, exp_o);
            chk("record", hif.rsp_record, raw_r);
            chk("err", hif.rsp_err, 0);
            chk("excl", hif.req_ready, 0);
            ref_prev = raw_o;
            so = hif.rsp_orbit; sr = hif.rsp_record;
            for (int h = 0; h < hold; h++) begin
                hif.req_valid = 1'($urandom_range(0, 1)); hif.req_num = $urandom;
                @(negedge clk);
                chk("hold_valid", hif.rsp_valid, 1);
                chk("hold_orbit", hif.rsp_orbit, so);
                chk("hold_record", hif.rsp_record, sr);
                chk("hold_ready", hif.req_ready, 0);
            end
            hif.req_valid = 1'b0;
            hif.rsp_ready = 1'b1;
            @(negedge clk);
            hif.rsp_ready = 1'b0;
            chk("rsp_done", hif.rsp_valid, 0);
            chk("back_idle", hif.req_ready, 1);
        end
    endtask

    initial begin
        int n;
        hif.req_valid = 0; hif.req_num = '0; hif.rsp_ready = 0;
        hif_to.req_valid = 0; hif_to.req_num = '0; hif_to.rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", hif.req_ready, 0);
        chk("rst_valid", hif.rsp_valid, 0);
        chk("rst_dev", {dev_ctrl, dev_wdata}, 16'h8000);
        chk("rst_res", {hif.rsp_err, hif.rsp_orbit, hif.rsp_record}, 65'h0);
        rst_n = 1'b1;

        run(32'h12345678, 50, 32'h0000000A, 32'h00000010, 0);
        run($urandom, 50, 32'h00000019, $urandom, 5);
        run($urandom, 10, 32'h00000004, $urandom, 0);
        for (int r = 0; r < 6; r++)
            run($urandom, $urandom_range(0, 30), $urandom, $urandom, $urandom_range(0, 3));

        @(negedge clk);
        hif_to.req_valid = 1'b1; hif_to.req_num = $urandom;
        @(negedge clk);
        hif_to.req_valid = 1'b0;
        n = 0;
        while (!hif_to.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 23);
        chk("to_err", hif_to.rsp_err, 1);
        chk("to_res", {hif_to.rsp_orbit, hif_to.rsp_record}, 64'h0);
        hif_to.rsp_ready = 1'b1;
        @(negedge clk);
        hif_to.rsp_ready = 1'b0;
        chk("lock_valid", hif_to.rsp_valid, 0);
        for (int i = 0; i < 5; i++) begin
            hif_to.req_valid = 1'b1;
            @(negedge clk);
            chk("lock_ready", hif_to.req_ready, 0);
            chk("lock_ctrl", to_ctrl, 8'h80);
        end
        hif_to.req_valid = 1'b0;

        set_busy = 50;
        @(negedge clk);
        hif.req_valid = 1'b1; hif.req_num = $urandom;
        @(negedge clk);
        hif.req_valid = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", hif.req_ready, 0);
        chk("arst_valid", hif.rsp_valid, 0);
        chk("arst_dev", {dev_ctrl, dev_wdata}, 16'h8000);
        chk("arst_res", {hif.rsp_err, hif.rsp_orbit, hif.rsp_record}, 65'h0);
        chk("arst_to", {hif_to.rsp_err, hif_to.req_ready}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_prev = '0;
        @(negedge clk);
        chk("rel_ready", hif.req_ready, 1);
        chk("rel_valid", hif.rsp_valid, 0);
        chk("rel_to_ready", hif_to.req_ready, 1);
        repeat (60) begin
            @(negedge clk);
            if (hif.rsp_valid) chk("no_rsp_after_rst", hif.rsp_valid, 0);
        end

        run($urandom, 5, 32'h00000077, $urandom, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/collatz_host.md
COLLATZ_HOST -- requirements
Module: collatz_host

Interface
REQ-001 Parameter BITS, default 32, operand/result width; SHALL be a multiple of 8 and at most 128; NBYTES = BITS/8.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'hFFFFFF, maximum POLL cycles before the run is declared failed.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low; shared with the attached accelerator.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_num  in  BITS  starting value, sampled at request handshake.
REQ-008 rsp_valid  out  1  response present.
REQ-009 rsp_ready  in  1  consumer accepts response.
REQ-010 rsp_orbit  out  BITS  orbit length of this run.
REQ-011 rsp_record  out  BITS  path record of this run.
REQ-012 rsp_err  out  1  run timed out; results invalid.
REQ-013 dev_wdata  out  8  byte to accelerator data input.
REQ-014 dev_ctrl  out  8  accelerator control: [7] 1=read/0=write, [6] start, [4] read select (0 orbit, 1 record), [3:0] byte address.
REQ-015 dev_rdata  in  8  accelerator registered read byte.
REQ-016 dev_busy  in  1  accelerator busy flag, meaningful only in compute mode.

Function
REQ-017 FSM states: IDLE, WRITE, START, ENTER, POLL, SETTLE, READ, RESP, LOCKED.
REQ-018 IDLE: req_ready=1, dev_ctrl=8'h80 (read mode, so the accelerator never captures dev_wdata), dev_wdata=0.
REQ-019 Handshake req_valid&&req_ready: latch req_num, go WRITE; req_ready SHALL be 0 in every state but IDLE.
REQ-020 WRITE: NBYTES cycles, k=0..NBYTES-1 ascending; dev_ctrl={4'b0000,k[3:0]}, dev_wdata=req_num[8k+:8] (little-endian).
REQ-021 START: one cycle, dev_ctrl=8'hC0; then ENTER.
REQ-022 ENTER: 2 cycles, dev_ctrl=8'h80, dev_busy ignored; then POLL.
REQ-023 POLL: dev_ctrl=8'h80; dev_busy=0 sampled -> SETTLE; cycle counter (cleared on entry) reaching TIMEOUT_CYCLES with dev_busy still 1 -> RESP with err.
REQ-024 SETTLE: one cycle, dev_ctrl=8'h80, lets accelerator return to IO mode; then READ.
REQ-025 READ: 2*NBYTES+1 cycles, pipelined; cycle j<NBYTES presents {1'b1,3'b000,j}, cycle NBYTES<=j<2*NBYTES presents {1'b1,3'b001,j-NBYTES}, last cycle presents 8'h80.
REQ-026 READ capture: in cycle j>=1 dev_rdata SHALL be stored as byte of the address presented in cycle j-1 (one-cycle accelerator read latency).
REQ-027 Accelerator orbit register accumulates across runs; rsp_orbit SHALL equal raw_orbit - prev_raw modulo 2^BITS; prev_raw updated to raw_orbit on READ exit; prev_raw reset value 0.
REQ-028 rsp_record SHALL equal the raw assembled record value.
REQ-029 RESP: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready; then IDLE, or LOCKED if rsp_err=1.
REQ-030 Timeout: rsp_err=1, rsp_orbit=0, rsp_record=0, no READ, prev_raw unchanged.
REQ-031 LOCKED: req_ready=0, rsp_valid=0, dev_ctrl=8'h80, no further accelerator access until rst_n asserted.
REQ-032 rsp_valid and req_ready SHALL never be 1 in the same cycle.
REQ-033 req_valid outside IDLE SHALL be ignored without side effect.

Reset
REQ-034 rst_n=0 SHALL immediately, asynchronously force: state IDLE, req_ready=0 while asserted, rsp_valid=0, rsp_err=0, rsp_orbit=0, rsp_record=0, dev_ctrl=8'h80, dev_wdata=0, counters and prev_raw 0.
REQ-035 Reset in any state, including mid-WRITE or POLL, SHALL abort the run with no response; first cycle after release req_ready=1.

Verification
REQ-036 req_num=32'h12345678 -> dev_ctrl/dev_wdata = 00/78, 01/56, 02/34, 03/12 on consecutive cycles, then dev_ctrl=C0 for exactly one cycle.
REQ-037 Device model busy 1 for 50 cycles, raw orbit 32'h0000000A, record 32'h00000010 -> rsp_orbit=10, rsp_record=16, rsp_err=0; READ addresses 80..83, 90..93, 80.
REQ-038 Second run, raw orbit 32'h00000019 -> rsp_orbit=15; third run raw orbit 32'h00000004 (wrapped model) -> rsp_orbit=32'hFFFFFFEB.
REQ-039 TIMEOUT_CYCLES=16, dev_busy held 1 -> rsp_err=1 after 16 POLL cycles, results 0; after handshake req_ready stays 0 until reset.
REQ-040 rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_* stable all 5 cycles; req_valid pulses ignored.
REQ-041 rst_n low during POLL -> outputs at reset values same cycle, no rsp_valid, req_ready=1 one cycle after release.
